// File: rtl/aes_pkg.sv
// AES-128 shared definitions: round count, Rcon table, byte/word/state types, GF(2^8) helpers.
// Pure combinational functions; no latency of their own.
// No flow control involved; functions are evaluated inside the pipeline stages.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  // Round constants, indexed by round number 1..10
  localparam byte_t RCON [1:NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of MixColumns; byte 0 (row 0) sits in the MSBs
  function automatic word_t mix_column(input word_t c);
    byte_t a0, a1, a2, a3;
    byte_t b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = xtime(a0);
    b1 = xtime(a1);
    b2 = xtime(a2);
    b3 = xtime(a3);
    return {b0 ^ b1 ^ a1 ^ a2 ^ a3,
            a0 ^ b1 ^ b2 ^ a2 ^ a3,
            a0 ^ a1 ^ b2 ^ b3 ^ a3,
            b0 ^ a0 ^ a1 ^ a2 ^ b3};
  endfunction

  // MixColumns on the full state; column c occupies bits [127-32c -: 32]
  function automatic state_t mix_columns(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  // ShiftRows: row r of column c takes row r of column (c+r) mod 4; byte 4c+r at [127-8(4c+r) -: 8]
  function automatic state_t shift_rows(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_encryption_sbox.sv
// Forward AES S-box lookup for one byte.
// Combinational, zero cycles.
// No flow control.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Table entry 0 in the MSBs; entry a ends at bit 2047-8a = {~a, 3'b111}
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = SBOX[{~i_byte, 3'b111} -: 8];

endmodule

// File: rtl/aes_encryption.sv
// Fully pipelined AES-128 encryptor: one block and key accepted every cycle, key travels with its data.
// Latency: inputs sampled at edge E appear on cipher_out right after edge E+10.
// No backpressure: no handshake, every edge advances the whole pipeline.
module aes_encryption
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] Data_in,
  input  logic [127:0] key_in,
  output logic [127:0] cipher_out
);

  // Stage r holds the state after round r; the last round key is consumed and never stored
  state_t r_state [0:NR];
  state_t r_rkey  [0:NR-1];

  // Stage 0: initial AddRoundKey and capture of the cipher key
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state[0] <= '0;
      r_rkey[0]  <= '0;
    end else begin
      r_state[0] <= Data_in ^ key_in;
      r_rkey[0]  <= key_in;
    end
  end

  for (genvar r = 1; r <= NR; r++) begin : g_round
    localparam bit FINAL = (r == NR);

    state_t w_sub;
    state_t w_shift;
    state_t w_rnd;
    state_t w_rk;
    word_t  w_rot;
    word_t  w_key_sub;
    word_t  w_temp;
    word_t  w_k0, w_k1, w_k2, w_k3;

    // SubBytes on all 16 state bytes
    for (genvar b = 0; b < 16; b++) begin : g_data_sbox
      aes_sbox u_sbox (
        .i_byte (r_state[r-1][127-8*b -: 8]),
        .o_byte (w_sub[127-8*b -: 8])
      );
    end

    assign w_shift = shift_rows(w_sub);

    if (FINAL) begin : g_last
      assign w_rnd = w_shift;
    end else begin : g_mid
      assign w_rnd = mix_columns(w_shift);
    end

    // Key schedule step: SubWord(RotWord(w3)) ^ Rcon, then chain through the four words
    assign w_rot = {r_rkey[r-1][23:0], r_rkey[r-1][31:24]};

    for (genvar k = 0; k < 4; k++) begin : g_key_sbox
      aes_sbox u_sbox (
        .i_byte (w_rot[31-8*k -: 8]),
        .o_byte (w_key_sub[31-8*k -: 8])
      );
    end

    assign w_temp = w_key_sub ^ {RCON[r], 24'h0};
    assign w_k0   = r_rkey[r-1][127:96] ^ w_temp;
    assign w_k1   = r_rkey[r-1][95:64]  ^ w_k0;
    assign w_k2   = r_rkey[r-1][63:32]  ^ w_k1;
    assign w_k3   = r_rkey[r-1][31:0]   ^ w_k2;
    assign w_rk   = {w_k0, w_k1, w_k2, w_k3};

    // Round register: AddRoundKey with the key derived in this same stage
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state[r] <= '0;
      end else begin
        r_state[r] <= w_rnd ^ w_rk;
      end
    end

    if (!FINAL) begin : g_key_reg
      // Forward the round key so the next stage can derive its own
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rkey[r] <= '0;
        end else begin
          r_rkey[r] <= w_rk;
        end
      end
    end
  end

  assign cipher_out = r_state[NR];

endmodule

// File: tb/tb_aes_encryption.sv
// Directed bench for the AES-128 pipeline using FIPS-197 known-answer vectors.
module tb_aes_encryption;

  logic         clk;
  logic         rst;
  logic [127:0] Data_in;
  logic [127:0] key_in;
  logic [127:0] cipher_out;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P3 = 128'h0;
  localparam logic [127:0] K3 = 128'h0;
  localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_encryption dut (
    .clk        (clk),
    .rst        (rst),
    .Data_in    (Data_in),
    .key_in     (key_in),
    .cipher_out (cipher_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ne(input string tag, input logic [127:0] obs, input logic [127:0] bad);
    checks++;
    assert (obs !== bad) else begin
      errors++;
      $error("FAIL %s observed=%h expected_not=%h", tag, obs, bad);
    end
  endtask

  initial begin
    // Reset held 3 cycles with changing arbitrary inputs
    rst     = 1'b1;
    Data_in = {$urandom, $urandom, $urandom, $urandom};
    key_in  = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("reset_hold", cipher_out, 128'h0);
      Data_in = {$urandom, $urandom, $urandom, $urandom};
      key_in  = {$urandom, $urandom, $urandom, $urandom};
    end

    // All-zero vector right after release: result 11 edges counting the first non-reset edge
    rst     = 1'b0;
    Data_in = P3;
    key_in  = K3;
    for (int i = 0; i < 11; i++) tick();
    check_eq("zero_vector", cipher_out, C3);

    // FIPS-197 appendix B vector held for 22 cycles
    Data_in = P1;
    key_in  = K1;
    for (int i = 0; i < 10; i++) tick();
    check_eq("fips_b_before", cipher_out, C3);
    tick();
    check_eq("fips_b_first", cipher_out, C1);
    for (int i = 0; i < 11; i++) begin
      tick();
      check_eq("fips_b_stable", cipher_out, C1);
    end

    // Appendix C.1 vector: exactly 10 cycles after the sampling edge
    Data_in = P2;
    key_in  = K2;
    for (int i = 0; i < 10; i++) tick();
    check_eq("fips_c1_before", cipher_out, C1);
    tick();
    check_eq("fips_c1_latency", cipher_out, C2);

    // Streaming three different blocks on consecutive edges
    Data_in = P1; key_in = K1; tick();
    Data_in = P2; key_in = K2; tick();
    Data_in = P3; key_in = K3; tick();
    for (int i = 0; i < 7; i++) tick();
    check_eq("stream_prior", cipher_out, C2);
    tick();
    check_eq("stream_0", cipher_out, C1);
    tick();
    check_eq("stream_1", cipher_out, C2);
    tick();
    check_eq("stream_2", cipher_out, C3);

    // Five blocks in flight, then a one-cycle reset flushes them
    Data_in = P1; key_in = K1; tick();
    Data_in = P2; key_in = K2; tick();
    Data_in = P1; key_in = K1; tick();
    Data_in = P2; key_in = K2; tick();
    Data_in = P1; key_in = K1; tick();
    check_eq("flush_pre", cipher_out, C3);
    rst = 1'b1;
    tick();
    check_eq("flush_reset", cipher_out, 128'h0);
    rst     = 1'b0;
    Data_in = P3;
    key_in  = K3;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_ne("flush_no_c1", cipher_out, C1);
      check_ne("flush_no_c2", cipher_out, C2);
    end
    check_eq("flush_recover", cipher_out, C3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_encryption.md
AES_ENCRYPTION -- requirements
Module: AES_Encryption

Interface
REQ-001 Parameters: none; fixed AES-128 (128-bit key, 10 rounds, FIPS-197).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 Data_in  input  128  plaintext block; bit 127 = first byte MSB, FIPS-197 column-major byte order.
REQ-005 key_in  input  128  cipher key; same byte ordering as Data_in.
REQ-006 cipher_out  output  128  ciphertext; registered; same byte ordering.

Function
REQ-007 The block SHALL be a fully pipelined AES-128 encryptor, with no handshake and no valid signals.
REQ-008 The block SHALL sample Data_in and key_in on every rising edge and accept one new block per cycle.
REQ-009 Stage 0 SHALL register state0 = Data_in XOR key_in, together with round key 0 = key_in.
REQ-010 Stage r (r=1..9) SHALL register the result of SubBytes, ShiftRows, MixColumns and AddRoundKey(rk_r) applied to stage r-1.
REQ-011 Stage 10 SHALL apply SubBytes, ShiftRows and AddRoundKey(rk10) with no MixColumns, and its register SHALL drive cipher_out.
REQ-012 Round key rk_r SHALL be derived from rk_(r-1) in the same stage as round r.
- Derivation: RotWord, SubWord, XOR Rcon[r] (01,02,04,08,10,20,40,80,1b,36), then word chaining.
- The key SHALL travel through the pipeline with its data.
REQ-013 Latency: inputs present before rising edge E SHALL appear on cipher_out immediately after edge E+10, i.e. 11 edges counting E.
REQ-014 Throughput: 1 block/cycle; consecutive edges with different inputs SHALL produce consecutive, independent ciphertexts.
REQ-015 If inputs are held constant, cipher_out SHALL be stable from edge E+10 onward.
REQ-016 MixColumns SHALL use GF(2^8) multiplication with polynomial 0x11b (xtime: shift left, XOR 0x1b if the MSB was set).
REQ-017 The S-box SHALL be the FIPS-197 forward S-box, e.g. S(00)=63, S(53)=ed.
REQ-018 Register-free X propagation: with rst never asserted, cipher_out SHALL become fully defined 11 edges after inputs become defined (no feedback state).

Reset
REQ-019 While rst=1 at a rising edge, all pipeline state and round-key registers SHALL clear to 0, and cipher_out SHALL be 128'h0.
REQ-020 On release of rst, the first valid ciphertext SHALL appear 11 edges after the first non-reset edge.
REQ-021 Reset asserted mid-stream SHALL discard all in-flight blocks, and SHALL NOT leave partial results on cipher_out.

Structure
REQ-022 Package aes_pkg SHALL hold:
- Constants: NR=10 and the Rcon table.
- Byte/word/state typedefs.
- The xtime function and the MixColumns function.
REQ-023 Sub-module aes_sbox (8-bit in, 8-bit out, combinational) SHALL be used for the 16 data S-boxes and the 4 key S-boxes in each round.
REQ-024 The rounds SHALL be generated from one round description with a final-round flag, and SHALL NOT be hand-copied.

Verification
REQ-025 Data_in=3243f6a8885a308d313198a2e0370734, key_in=2b7e151628aed2a6abf7158809cf4f3c held for 22 cycles -> cipher_out=3925841d02dc09fbdc118597196a0b32.
REQ-026 Data_in=00112233445566778899aabbccddeeff, key_in=000102030405060708090a0b0c0d0e0f -> cipher_out=69c4e0d86a7b0430d8cdb78070b4c55a, exactly 10 cycles after the sampling edge.
REQ-027 All-zero Data_in and all-zero key_in after reset release -> cipher_out=66e94bd4ef8a2c3b884cfa59ca342b2e.
REQ-028 Streaming test: apply the REQ-025, REQ-026 and REQ-027 vectors on three consecutive edges -> the three ciphertexts appear on three consecutive cycles, in order.
REQ-029 Assert rst for 1 cycle while 5 blocks are in flight -> cipher_out=0 on the next edge, with none of the flushed results appearing afterward.
REQ-030 Reset check: rst high for 3 cycles with arbitrary inputs -> cipher_out=0 throughout.
